// File: rtl/timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_pkg : shared types and constants for the 555 phase sequencer    |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHARGE    = 2'd1,
    DISCHARGE = 2'd2,
    FAULT     = 2'd3
  } state_e;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_MONO    = 2'b01;
  localparam logic [1:0] MODE_ASTABLE = 2'b10;
  localparam logic [1:0] MODE_BURST   = 2'b11;

  localparam int PULSE_W = 9;

  // A burst length of zero stands for 256 pulses.
  function automatic logic [PULSE_W-1:0] burst_target(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_sync : N-stage flop synchronizer, async active-low reset        |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
module timer_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/timer_phase_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_phase_sequencer : clocked phase FSM replacing the 555 SR latch  |
// | Revision              : 1.0                                           |
// +----------------------------------------------------------------------+
module timer_phase_sequencer
  import timer_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             trig_cmp,
  input  logic             thresh_cmp,
  input  logic [7:0]       burst_len,
  input  logic [3:0]       blank_cyc,
  output logic             out,
  output logic             discharge,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hi_cnt,
  output logic [CNT_W-1:0] lo_cnt,
  output logic             meas_valid,
  output logic             fault
);

  logic trig_s;
  logic thresh_s;
  logic start_s;

  timer_sync #(.STAGES(SYNC_STAGES)) u_sync_trig (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (trig_cmp),
    .q    (trig_s)
  );

  timer_sync #(.STAGES(SYNC_STAGES)) u_sync_thresh (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (thresh_cmp),
    .q    (thresh_s)
  );

  timer_sync #(.STAGES(SYNC_STAGES)) u_sync_start (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (start),
    .q    (start_s)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   phase_cnt_q, phase_cnt_d;
  logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0]   hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0]   lo_cnt_q, lo_cnt_d;
  logic               start_prev_q, start_prev_d;
  logic               start_rise_q, start_rise_d;
  logic               done_q, done_d;
  logic               meas_valid_q, meas_valid_d;
  logic               out_q, out_d;
  logic               discharge_q, discharge_d;

  logic               phase_max;
  logic               armed;
  logic [PULSE_W-1:0] pulse_next;
  logic [CNT_W-1:0]   phase_len;

  assign phase_max  = (phase_cnt_q == {CNT_W{1'b1}});
  assign armed      = (phase_cnt_q >= CNT_W'(blank_cyc));
  assign pulse_next = pulse_cnt_q + 9'd1;
  // Duration of the phase being left, counting the exit cycle itself.
  assign phase_len  = phase_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    start_prev_d = start_s;
    // Registered edge detect: adds one cycle of start latency.
    start_rise_d = start_s & ~start_prev_q;
  end

  always_comb begin
    state_d      = state_q;
    pulse_cnt_d  = pulse_cnt_q;
    hi_cnt_d     = hi_cnt_q;
    lo_cnt_d     = lo_cnt_q;
    done_d       = 1'b0;
    meas_valid_d = 1'b0;

    if (mode == MODE_OFF) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_rise_q) begin
            state_d     = CHARGE;
            pulse_cnt_d = '0;
          end
        end
        CHARGE: begin
          if (phase_max || (armed && trig_s && thresh_s)) begin
            state_d = FAULT;
          end else if (armed && thresh_s) begin
            hi_cnt_d = phase_len;
            if (mode == MODE_MONO) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = DISCHARGE;
            end
          end
        end
        DISCHARGE: begin
          if (phase_max || (armed && trig_s && thresh_s)) begin
            state_d = FAULT;
          end else if (armed && trig_s) begin
            lo_cnt_d     = phase_len;
            meas_valid_d = 1'b1;
            if (mode == MODE_BURST) begin
              pulse_cnt_d = pulse_next;
              if (pulse_next == burst_target(burst_len)) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = CHARGE;
              end
            end else if (mode == MODE_ASTABLE) begin
              state_d = CHARGE;
            end else begin
              // Switched to monostable mid-period: finish as a one-shot.
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (state_d != state_q) begin
      phase_cnt_d = '0;
    end else if (phase_max) begin
      phase_cnt_d = phase_cnt_q;
    end else begin
      phase_cnt_d = phase_len;
    end

    out_d       = (state_d == CHARGE);
    discharge_d = (state_d != CHARGE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_cnt_q  <= '0;
      pulse_cnt_q  <= '0;
      hi_cnt_q     <= '0;
      lo_cnt_q     <= '0;
      start_prev_q <= 1'b0;
      start_rise_q <= 1'b0;
      done_q       <= 1'b0;
      meas_valid_q <= 1'b0;
      out_q        <= 1'b0;
      discharge_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      phase_cnt_q  <= phase_cnt_d;
      pulse_cnt_q  <= pulse_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      lo_cnt_q     <= lo_cnt_d;
      start_prev_q <= start_prev_d;
      start_rise_q <= start_rise_d;
      done_q       <= done_d;
      meas_valid_q <= meas_valid_d;
      out_q        <= out_d;
      discharge_q  <= discharge_d;
    end
  end

  assign out        = out_q;
  assign discharge  = discharge_q;
  assign busy       = (state_q == CHARGE) || (state_q == DISCHARGE);
  assign fault      = (state_q == FAULT);
  assign done       = done_q;
  assign meas_valid = meas_valid_q;
  assign hi_cnt     = hi_cnt_q;
  assign lo_cnt     = lo_cnt_q;

endmodule
`default_nettype wire

// File: doc/timer_phase_sequencer.md
# timer_phase_sequencer

Digital control core for the HBT 555 timer macro. It sits between the analog comparator outputs (trigger and threshold) and the discharge-transistor drive. It replaces the classic 555 SR latch with a clocked phase state machine that supports monostable, astable and counted-burst modes, comparator blanking, phase-duration measurement and fault detection. The top-level logic manager instantiates it and maps its ports onto `ui_in`, `uo_out` and `uio`.

## Interface
- `CNT_W`, 16: width of the phase counter and the measurement outputs.
- `SYNC_STAGES`, 2: flop depth of the input synchronizers (≥2).
- `clk` in 1: single system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mode` in 2: 00 off, 01 monostable, 10 astable, 11 burst. Quasi-static.
- `start` in 1: asynchronous pin. A rising edge launches a cycle.
- `trig_cmp` in 1: asynchronous. High when TRIG < 1/3 Vcc.
- `thresh_cmp` in 1: asynchronous. High when THRESH > 2/3 Vcc.
- `burst_len` in 8: pulses per burst. 0 means 256.
- `blank_cyc` in 4: cycles after phase entry during which comparators are ignored.
- `out` out 1: timer output, registered.
- `discharge` out 1: discharge drive, registered. 1 shorts the capacitor.
- `busy` out 1: state is CHARGE or DISCHARGE.
- `done` out 1: one-cycle pulse at the normal end of a one-shot or burst.
- `hi_cnt`, `lo_cnt` out CNT_W: last measured CHARGE / DISCHARGE duration, in clk cycles.
- `meas_valid` out 1: one-cycle pulse when `lo_cnt` updates (full period captured).
- `fault` out 1: high while in FAULT.

## Operation
- `trig_cmp`, `thresh_cmp` and `start` each pass through a SYNC_STAGES synchronizer, giving `trig_s`, `thresh_s` and `start_s`.
- `start_rise` = `start_s` & ~previous `start_s`.
- States:
  - IDLE: out=0, discharge=1.
  - CHARGE: out=1, discharge=0.
  - DISCHARGE: out=0, discharge=1.
  - FAULT: out=0, discharge=1.
- `phase_cnt` clears to 0 on every state entry and increments each cycle.
- `armed` = (`phase_cnt` ≥ `blank_cyc`).
- Transitions are listed in priority order (first match wins).
  - Any state, mode==00: go to IDLE. This clears FAULT, produces no `done`, and leaves `hi_cnt`/`lo_cnt` unchanged.
  - CHARGE/DISCHARGE, `phase_cnt` == all-ones: go to FAULT.
  - CHARGE/DISCHARGE, `armed` & `trig_s` & `thresh_s`: go to FAULT.
  - IDLE, mode≠00 & `start_rise`: go to CHARGE and load `pulse_cnt` = 0.
  - CHARGE, `armed` & `thresh_s`:
    - `hi_cnt` ← `phase_cnt`+1.
    - Monostable: go to IDLE and pulse `done`.
    - Otherwise: go to DISCHARGE.
  - DISCHARGE, `armed` & `trig_s`:
    - `lo_cnt` ← `phase_cnt`+1 and pulse `meas_valid`.
    - Astable: go to CHARGE.
    - Burst: `pulse_cnt`++. If the new count equals the effective `burst_len`, go to IDLE and pulse `done`. Otherwise go to CHARGE.
- `start_rise` outside IDLE is ignored: no retrigger, no queueing.
- A mode change between nonzero values mid-cycle takes effect at the next phase exit decision.
- FAULT persists until mode==00. A start edge does not clear it.

## Timing
- Reset values:
  - state IDLE: out=0, discharge=1.
  - busy=0, done=0, meas_valid=0, fault=0.
  - `hi_cnt`=0, `lo_cnt`=0.
  - `phase_cnt`=0, `pulse_cnt`=0.
  - All synchronizer flops 0.
- Reset asserted mid-operation returns everything to these values immediately (asynchronous).
- Pin edge to state change: SYNC_STAGES+1 cycles. The registered output follows in the same edge as the state register.
- Start latency: `start` rises → `out` high after SYNC_STAGES+2 edges (edge detect adds 1).
- Duration counts equal the exact number of cycles the state register held CHARGE/DISCHARGE.
- `phase_cnt` saturates; it never wraps.
- `done`, `meas_valid`, `hi_cnt` and `lo_cnt` are registered and update on the same edge as the exiting state transition.

## Structure
- Package `timer_pkg`:
  - state enum (IDLE, CHARGE, DISCHARGE, FAULT).
  - mode constants MODE_OFF, MODE_MONO, MODE_ASTABLE, MODE_BURST.
- Sub-module `timer_sync`: parameterized N-stage synchronizer with async active-low reset. Instantiated three times.
- The FSM, counters and measurement registers live in `timer_phase_sequencer`.

## Test plan
- Monostable, blank_cyc=3: start pulse; thresh_cmp rises 20 cycles after out rises → out high exactly 20+SYNC delay-consistent cycles, `hi_cnt` equals counted out-high cycles, one `done`, discharge back to 1.
- Astable, comparators driven by an RC model (20 high / 10 low cycles) → continuous oscillation, `meas_valid` once per period, `hi_cnt`/`lo_cnt` stable at measured values, `done` never asserted.
- Burst, burst_len=3 → exactly 3 out pulses then IDLE with a single `done`. Repeat with burst_len=0 → 256 pulses.
- Blanking, blank_cyc=5: thresh_cmp held high throughout CHARGE entry → no exit before `phase_cnt`=5, exit immediately after.
- Faults:
  - trig_cmp and thresh_cmp both high when armed → FAULT, out=0, discharge=1. Start edge ignored. mode=00 → IDLE, fault=0.
  - CNT_W=6 with no comparator activity → FAULT after 63 cycles.
- rst_n pulled low mid-CHARGE → outputs at reset values without a clock edge. After release, no activity until a new start edge.
